wb_slave_mux: RTL and testbench

//  Single-master to NUM_SLAVES Wishbone pipelined decoder/mux with one outstanding

---
 rtl/wb_slave_mux_if.sv | 47 ++++
 rtl/wb_slave_mux.sv | 157 +++++++++++++++
 tb/tb_wb_slave_mux.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_mux_if.sv
// Bus bundle for wb_slave_mux: CPU-side Wishbone pipelined port plus the fan-out to NUM_SLAVES peripherals.
// Handshake: a request transfers on a clock edge where m_cyc&m_stb&!m_stall (slave side: s_stb&!s_stall); a response is a one-cycle ack or err pulse.
interface wb_slave_mux_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic                         m_cyc;
  logic                         m_stb;
  logic                         m_we;
  logic [ADDR_W-1:0]            m_adr;
  logic [DATA_W/8-1:0]          m_sel;
  logic [DATA_W-1:0]            m_dat_i;
  logic [DATA_W-1:0]            m_dat_o;
  logic                         m_ack;
  logic                         m_err;
  logic                         m_stall;
  logic [NUM_SLAVES-1:0]        s_cyc;
  logic [NUM_SLAVES-1:0]        s_stb;
  logic                         s_we;
  logic [ADDR_W-1:0]            s_adr;
  logic [DATA_W/8-1:0]          s_sel;
  logic [DATA_W-1:0]            s_dat_o;
  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0]        s_ack;
  logic [NUM_SLAVES-1:0]        s_err;
  logic [NUM_SLAVES-1:0]        s_stall;
  logic                         busy;

  // The decoder/mux itself: a slave towards the CPU, a master towards the peripherals.
  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_i,
    output m_dat_o, m_ack, m_err, m_stall,
    output s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_o,
    input  s_dat_i, s_ack, s_err, s_stall,
    output busy
  );

  // The environment around the mux: CPU master plus peripheral responders.
  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_i,
    input  m_dat_o, m_ack, m_err, m_stall,
    input  s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_o,
    output s_dat_i, s_ack, s_err, s_stall,
    input  busy
  );
endinterface

// File: rtl/wb_slave_mux.sv
// Single-master Wishbone pipelined address decoder/mux with one outstanding transaction,
// decode-miss error and per-transaction response timeout.
module wb_slave_mux #(
  parameter int                           NUM_SLAVES     = 4,
  parameter int                           ADDR_W         = 32,
  parameter int                           DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = '0,
  parameter int                           TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  wb_slave_mux_if.slave       bus,
  output logic [1:0]          state_dbg_o
);
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DECERR} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic                we_q, we_d;
  logic [DATA_W/8-1:0] sel_q, sel_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [DATA_W-1:0]   m_dat_q, m_dat_d;
  logic                m_ack_q, m_ack_d;
  logic                m_err_q, m_err_d;

  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [NUM_SLAVES-1:0] idx_oh;
  logic                sel_ack, sel_err, sel_stall, respond;
  logic [DATA_W-1:0]   sel_dat;

  // Scan from the top down so the lowest matching window wins on overlap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((bus.m_adr & SLAVE_MASK[k*ADDR_W +: ADDR_W]) == SLAVE_BASE[k*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  // Only the latched target's response lines are ever looked at.
  always_comb begin
    idx_oh    = '0;
    sel_ack   = 1'b0;
    sel_err   = 1'b0;
    sel_stall = 1'b0;
    sel_dat   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        idx_oh[k] = 1'b1;
        sel_ack   = bus.s_ack[k];
        sel_err   = bus.s_err[k];
        sel_stall = bus.s_stall[k];
        sel_dat   = bus.s_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    m_dat_d = m_dat_q;
    m_ack_d = 1'b0;
    m_err_d = 1'b0;
    // A response in ISSUE only counts once the slave has taken the strobe.
    respond = ((state_q == S_WAIT) || !sel_stall) && (sel_ack || sel_err);
    unique case (state_q)
      S_IDLE: begin
        if (bus.m_cyc && bus.m_stb) begin
          adr_d   = bus.m_adr;
          we_d    = bus.m_we;
          sel_d   = bus.m_sel;
          wdat_d  = bus.m_dat_i;
          idx_d   = hit_idx;
          cnt_d   = '0;
          state_d = hit ? S_ISSUE : S_DECERR;
        end
      end
      S_DECERR: begin
        m_err_d = 1'b1;
        state_d = S_IDLE;
      end
      S_ISSUE, S_WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (!bus.m_cyc) begin
          state_d = S_IDLE;
        end else if (respond) begin
          state_d = S_IDLE;
          m_err_d = sel_err;
          m_ack_d = !sel_err;
          if (!sel_err && !we_q) m_dat_d = sel_dat;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          m_err_d = 1'b1;
        end else if ((state_q == S_ISSUE) && !sel_stall) begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      m_dat_q <= '0;
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      m_dat_q <= m_dat_d;
      m_ack_q <= m_ack_d;
      m_err_q <= m_err_d;
    end
  end

  assign bus.m_dat_o  = m_dat_q;
  assign bus.m_ack    = m_ack_q;
  assign bus.m_err    = m_err_q;
  assign bus.m_stall  = (state_q != S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.s_cyc    = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? idx_oh : '0;
  assign bus.s_stb    = (state_q == S_ISSUE) ? idx_oh : '0;
  assign bus.s_we     = we_q;
  assign bus.s_adr    = adr_q;
  assign bus.s_sel    = sel_q;
  assign bus.s_dat_o  = wdat_q;
  assign state_dbg_o  = state_q;
endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed bench for wb_slave_mux: table of single transactions plus hand-written
// timeout, abort and reset-in-flight sequences against a configurable slave responder.
module tb_wb_slave_mux;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [NS*AW-1:0] BASE = {32'h1000_2000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  logic [3:0] resp_ack, resp_err, resp_stall, man_ack;
  int         n_chk, n_fail;

  // Responder configuration: mode 0 ack, 1 err, 2 ack+err, 3 never answer.
  int         stall_n, resp_mode;
  int         st_cnt, cur_idx, pend_idx;
  bit         pend;

  wb_slave_mux_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_slave_mux #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg_o(state_dbg)
  );

  assign bus.s_ack   = resp_ack | man_ack;
  assign bus.s_err   = resp_err;
  assign bus.s_stall = resp_stall;
  assign bus.s_dat_i = {32'h5555_6666, 32'h3333_4444, 32'h1111_2222, 32'hDEAD_BEEF};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: stalls stall_n cycles, answers the cycle after accepting the strobe.
  // Unselected slaves stall and signal err permanently, which must have no effect.
  always @(negedge clk) begin
    resp_ack   = '0;
    resp_err   = '0;
    resp_stall = '0;
    if (rst) begin
      pend   = 1'b0;
      st_cnt = 0;
    end else begin
      if (pend) begin
        if (resp_mode != 1) resp_ack[pend_idx] = 1'b1;
        if (resp_mode != 0) resp_err[pend_idx] = 1'b1;
        pend = 1'b0;
      end
      for (int k = 0; k < NS; k++) if (bus.s_stb[k]) cur_idx = k;
      if (|bus.s_stb) begin
        if (st_cnt < stall_n) begin
          resp_stall[cur_idx] = 1'b1;
          st_cnt++;
        end else begin
          st_cnt   = 0;
          pend     = (resp_mode != 3);
          pend_idx = cur_idx;
        end
      end
      for (int k = 0; k < NS; k++) begin
        if (k != cur_idx) begin
          resp_stall[k] = 1'b1;
          resp_err[k]   = 1'b1;
        end
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          stall_n;
    int          mode;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
    logic [3:0]  exp_stb;
    int          exp_stb_cyc;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    @(negedge clk);
    bus.m_cyc   = 1'b1;
    bus.m_stb   = 1'b1;
    bus.m_we    = we;
    bus.m_adr   = adr;
    bus.m_dat_i = dat;
    bus.m_sel   = sel;
    @(posedge clk);
    #1 bus.m_stb = 1'b0;
  endtask

  // Latency counts negedges after the accepting edge: first negedge is T1.
  task automatic run_txn(input string tag, input vec_t v);
    logic [3:0]  stb_acc;
    int          stb_cyc, lat;
    bit          bcast_ok, stall_ok, done;
    logic        got_ack, got_err, busy_resp;
    logic [3:0]  scyc_resp;
    logic [31:0] got_dat;
    stall_n   = v.stall_n;
    resp_mode = v.mode;
    stb_acc   = '0;
    stb_cyc   = 0;
    lat       = 0;
    bcast_ok  = 1'b1;
    stall_ok  = 1'b1;
    done      = 1'b0;
    got_ack   = 1'b0;
    got_err   = 1'b0;
    busy_resp = 1'b0;
    scyc_resp = '0;
    got_dat   = '0;
    start_req(v.we, v.adr, v.dat, v.sel);
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      if (|bus.s_stb) begin
        stb_acc |= bus.s_stb;
        stb_cyc++;
        if (bus.s_adr !== v.adr || bus.s_we !== v.we || bus.s_sel !== v.sel || bus.s_dat_o !== v.dat)
          bcast_ok = 1'b0;
      end
      if (bus.m_ack || bus.m_err) begin
        done      = 1'b1;
        lat       = n;
        got_ack   = bus.m_ack;
        got_err   = bus.m_err;
        got_dat   = bus.m_dat_o;
        scyc_resp = bus.s_cyc;
        busy_resp = bus.busy;
      end else if (!(bus.m_stall && bus.busy)) begin
        stall_ok = 1'b0;
      end
    end
    bus.m_cyc = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s no_response: got none within 40 cycles, expected ack/err", tag);
    end else begin
      chk({tag, " stb_mask"},  64'(stb_acc),   64'(v.exp_stb));
      chk({tag, " stb_cycles"}, 64'(stb_cyc),  64'(v.exp_stb_cyc));
      chk({tag, " bcast"},     64'(bcast_ok),  64'(1));
      chk({tag, " ack"},       64'(got_ack),   64'(v.exp_ack));
      chk({tag, " err"},       64'(got_err),   64'(v.exp_err));
      chk({tag, " latency"},   64'(lat),       64'(v.exp_lat));
      chk({tag, " rdata"},     64'(got_dat),   64'(v.exp_dat));
      chk({tag, " stall"},     64'(stall_ok),  64'(1));
      chk({tag, " scyc_resp"}, 64'(scyc_resp), 64'(0));
      chk({tag, " busy_resp"}, 64'(busy_resp), 64'(0));
    end
  endtask

  initial begin
    vec_t v;
    n_chk     = 0;
    n_fail    = 0;
    stall_n   = 0;
    resp_mode = 0;
    st_cnt    = 0;
    cur_idx   = 0;
    pend_idx  = 0;
    pend      = 1'b0;
    man_ack   = '0;
    rst       = 1'b1;
    bus.m_cyc = 1'b0; bus.m_stb = 1'b0; bus.m_we = 1'b0;
    bus.m_adr = '0;   bus.m_sel = '0;   bus.m_dat_i = '0;

    //            we    adr            dat            sel   stl md ack err exp_dat        stb    cyc lat
    vecs[0] = '{1'b1, 32'h1000_0000, 32'h0000_0001, 4'hF, 0, 0, 1, 0, 32'h0000_0000, 4'h1, 1, 3};
    vecs[1] = '{1'b0, 32'h1000_0004, 32'h0000_0000, 4'hF, 0, 0, 1, 0, 32'hDEAD_BEEF, 4'h1, 1, 3};
    vecs[2] = '{1'b0, 32'h1000_1010, 32'h0000_0000, 4'hF, 0, 0, 1, 0, 32'h1111_2222, 4'h2, 1, 3};
    vecs[3] = '{1'b0, 32'h1000_2008, 32'h0000_0000, 4'hF, 0, 0, 1, 0, 32'h3333_4444, 4'h4, 1, 3};
    vecs[4] = '{1'b0, 32'h1000_3000, 32'h0000_0000, 4'hF, 0, 0, 1, 0, 32'h5555_6666, 4'h8, 1, 3};
    vecs[5] = '{1'b0, 32'h2000_0000, 32'h0000_0000, 4'hF, 0, 0, 0, 1, 32'h5555_6666, 4'h0, 0, 2};
    vecs[6] = '{1'b1, 32'h1000_1000, 32'hA5A5_0F0F, 4'h3, 3, 0, 1, 0, 32'h5555_6666, 4'h2, 4, 6};
    vecs[7] = '{1'b0, 32'h1000_2010, 32'h0000_0000, 4'hF, 0, 1, 0, 1, 32'h5555_6666, 4'h4, 1, 3};
    vecs[8] = '{1'b0, 32'h1000_0008, 32'h0000_0000, 4'hF, 0, 2, 0, 1, 32'h5555_6666, 4'h1, 1, 3};
    vecs[9] = '{1'b1, 32'h1000_3FFC, 32'h1234_5678, 4'h8, 0, 0, 1, 0, 32'h5555_6666, 4'h8, 1, 3};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst m_ack",   64'(bus.m_ack),   64'(0));
    chk("rst m_err",   64'(bus.m_err),   64'(0));
    chk("rst m_dat_o", 64'(bus.m_dat_o), 64'(0));
    chk("rst s_cyc",   64'(bus.s_cyc),   64'(0));
    chk("rst s_stb",   64'(bus.s_stb),   64'(0));
    chk("rst s_adr",   64'(bus.s_adr),   64'(0));
    chk("rst m_stall", 64'(bus.m_stall), 64'(0));
    chk("rst busy",    64'(bus.busy),    64'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Timeout: slave accepts but never answers; err 8 cycles after ISSUE entry (T9).
    v = '{1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, 3, 0, 1, 32'h5555_6666, 4'h1, 1, 9};
    run_txn("timeout", v);
    man_ack[0] = 1'b1;
    @(negedge clk);
    man_ack[0] = 1'b0;
    chk("late_ack m_ack", 64'(bus.m_ack), 64'(0));
    chk("late_ack m_err", 64'(bus.m_err), 64'(0));
    chk("late_ack busy",  64'(bus.busy),  64'(0));

    // Abort in WAIT with a same-cycle ack that must be ignored.
    stall_n   = 0;
    resp_mode = 3;
    start_req(1'b0, 32'h1000_0000, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("abort in_wait s_cyc", 64'(bus.s_cyc), 64'(1));
    chk("abort in_wait s_stb", 64'(bus.s_stb), 64'(0));
    bus.m_cyc  = 1'b0;
    man_ack[0] = 1'b1;
    @(negedge clk);
    man_ack[0] = 1'b0;
    chk("abort s_cyc", 64'(bus.s_cyc), 64'(0));
    chk("abort busy",  64'(bus.busy),  64'(0));
    chk("abort m_ack", 64'(bus.m_ack), 64'(0));
    chk("abort m_err", 64'(bus.m_err), 64'(0));
    @(negedge clk);
    chk("abort next m_ack", 64'(bus.m_ack), 64'(0));
    chk("abort next m_err", 64'(bus.m_err), 64'(0));
    v = vecs[0];
    v.exp_dat = 32'h5555_6666;
    run_txn("after_abort", v);

    // Reset asserted mid-WAIT clears outputs without waiting for a clock edge.
    resp_mode = 3;
    start_req(1'b1, 32'h1000_1004, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid pre s_cyc", 64'(bus.s_cyc), 64'(2));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid s_cyc",   64'(bus.s_cyc),   64'(0));
    chk("rst_mid busy",    64'(bus.busy),    64'(0));
    chk("rst_mid m_stall", 64'(bus.m_stall), 64'(0));
    chk("rst_mid s_adr",   64'(bus.s_adr),   64'(0));
    chk("rst_mid m_dat_o", 64'(bus.m_dat_o), 64'(0));
    @(negedge clk);
    rst       = 1'b0;
    bus.m_cyc = 1'b0;
    chk("rst_mid after m_ack", 64'(bus.m_ack), 64'(0));
    run_txn("after_rst", vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
